// File: rtl/hdmi_unpack_pkg.sv
// Shared types and helpers for the HDMI pixel unpacker.
// Ratio and lane-width helpers keep the derivation in one place for every file.
package hdmi_unpack_pkg;

  // ARMED waits for a frame start with data ready; RUN streams pixels until reset.
  typedef enum logic {
    ARMED = 1'b0,
    RUN   = 1'b1
  } unpack_state_t;

  // Width of the saturating underflow counter.
  localparam int UFCNT_W = 16;

  // Pixels packed into one FIFO word (1, 2 or 4).
  function automatic int unpack_ratio(input int in_w, input int pix_w);
    return in_w / pix_w;
  endfunction

  // Lane counter width. RATIO=1 still gets a 1-bit counter so the vector is never
  // zero width; that bit is held at 0.
  function automatic int unpack_lane_w(input int ratio);
    return (ratio > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/hdmi_unpack_lane_mux.sv
// Combinational lane select: picks one c_PIX_WIDTH pixel out of a packed
// c_IN_WIDTH word. Lane 0 is the least significant pixel.
module hdmi_unpack_lane_mux
  import hdmi_unpack_pkg::*;
#(
  parameter int c_IN_WIDTH  = 32,
  parameter int c_PIX_WIDTH = 16,
  parameter int c_LANE_W    = 1
) (
  input  logic [c_IN_WIDTH-1:0]  word,
  input  logic [c_LANE_W-1:0]    lane,
  output logic [c_PIX_WIDTH-1:0] pix
);

  localparam int RATIO = unpack_ratio(c_IN_WIDTH, c_PIX_WIDTH);

  // Unrolled compare-and-select; lane codes past RATIO-1 never occur.
  always_comb begin
    pix = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == c_LANE_W'(i)) begin
        pix = word[i*c_PIX_WIDTH +: c_PIX_WIDTH];
      end
    end
  end

endmodule

// File: rtl/hdmi_pixel_unpack.sv
// HDMI pixel unpacker: pops packed words from a show-ahead FIFO and emits one
// pixel per data-enable cycle, with syncs delayed to match the pixel latency.
// Optional feature: define HDMI_UNPACK_UFCNT_EN to build the saturating
// underflow counter; otherwise underflow_cnt is tied to 0.
//
// FIFO handshake: a word transfers on a cycle where fifo_vld & fifo_en are both
// high. fifo_data is valid whenever fifo_vld is high (show-ahead), fifo_en may be
// raised while fifo_vld is low (ignored by the FIFO), and fifo_en never depends
// combinationally on fifo_vld.
module hdmi_pixel_unpack
  import hdmi_unpack_pkg::*;
#(
  parameter int                     c_IN_WIDTH  = 32,
  parameter int                     c_PIX_WIDTH = 16,
  parameter logic [c_PIX_WIDTH-1:0] c_BLANK_PIX = '0
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic [c_IN_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_vld,
  output logic                   fifo_en,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [c_PIX_WIDTH-1:0] pix_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   underflow,
  output logic [UFCNT_W-1:0]     underflow_cnt,
  output logic                   armed
);

  localparam int RATIO  = unpack_ratio(c_IN_WIDTH, c_PIX_WIDTH);
  localparam int LANE_W = unpack_lane_w(RATIO);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

  unpack_state_t state;
  unpack_state_t state_nxt;

  logic                   vs_q;
  logic                   vs_edge;
  logic                   run;
  logic                   pix_take;
  logic                   uf_nxt;
  logic [LANE_W-1:0]      lane;
  logic [LANE_W-1:0]      lane_eff;
  logic [LANE_W-1:0]      lane_step;
  logic [LANE_W-1:0]      lane_nxt;
  logic [c_PIX_WIDTH-1:0] lane_pix;
  logic [c_PIX_WIDTH-1:0] pix_nxt;

  // A frame starts on the rising edge of vsync.
  assign vs_edge = vs_i & ~vs_q;

  // State register.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: arm into RUN only when a frame starts with data already waiting.
  always_comb begin
    state_nxt = state;
    if ((state == ARMED) && vs_edge && fifo_vld) begin
      state_nxt = RUN;
    end
  end

  // State-decoded outputs: pop on the last lane of a word, blank when no data.
  // The pop is held off during reset so a mid-line reset never consumes a word.
  always_comb begin
    run      = (state == RUN);
    armed    = run;
    fifo_en  = run & de_i & (lane_eff == LANE_LAST) & ~rd_rst;
    pix_take = run & de_i & fifo_vld;
    uf_nxt   = run & de_i & ~fifo_vld;
    pix_nxt  = pix_take ? lane_pix : c_BLANK_PIX;
  end

  // Lane tracking follows screen position: a frame start forces lane 0 for the
  // current cycle, and every RUN data-enable advances it even on underflow.
  always_comb begin
    lane_eff  = vs_edge ? '0 : lane;
    lane_step = (lane_eff == LANE_LAST) ? '0 : (lane_eff + LANE_W'(1));
    lane_nxt  = lane;
    if (vs_edge) begin
      lane_nxt = de_i ? lane_step : '0;
    end else if (run && de_i) begin
      lane_nxt = lane_step;
    end
  end

  hdmi_unpack_lane_mux #(
    .c_IN_WIDTH  (c_IN_WIDTH),
    .c_PIX_WIDTH (c_PIX_WIDTH),
    .c_LANE_W    (LANE_W)
  ) u_lane_mux (
    .word (fifo_data),
    .lane (lane_eff),
    .pix  (lane_pix)
  );

  // Lane counter, vsync history and the one-cycle output pipeline.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      lane      <= '0;
      vs_q      <= 1'b0;
      pix_o     <= c_BLANK_PIX;
      de_o      <= 1'b0;
      hs_o      <= 1'b0;
      vs_o      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      lane      <= lane_nxt;
      vs_q      <= vs_i;
      pix_o     <= pix_nxt;
      de_o      <= de_i;
      hs_o      <= hs_i;
      vs_o      <= vs_i;
      underflow <= uf_nxt;
    end
  end

`ifdef HDMI_UNPACK_UFCNT_EN
  logic [UFCNT_W-1:0] uf_cnt;

  // Count registered underflow pulses, sticking at all-ones.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      uf_cnt <= '0;
    end else if (underflow && (uf_cnt != '1)) begin
      uf_cnt <= uf_cnt + UFCNT_W'(1);
    end
  end

  assign underflow_cnt = uf_cnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_pixel_unpack.sv
// Directed testbench for hdmi_pixel_unpack (default parameters, RATIO=2).
// A show-ahead FIFO is modelled with a queue; outputs are sampled #1 after
// the rising edge that registered them.
module tb_hdmi_pixel_unpack;

  logic        rd_clk;
  logic        rd_rst;
  logic [31:0] fifo_data;
  logic        fifo_vld;
  logic        fifo_en;
  logic        de_i;
  logic        hs_i;
  logic        vs_i;
  logic [15:0] pix_o;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic        armed;

  logic [31:0] exp_q[$];   // FIFO contents (show-ahead model)
  int          total;
  int          bad;
  logic        en_seen;    // fifo_en value in the last driven cycle
  int          pop_cnt;    // completed pops since last clear
  int          en_cnt;     // cycles with fifo_en high since last clear

  hdmi_pixel_unpack dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .fifo_data     (fifo_data),
    .fifo_vld      (fifo_vld),
    .fifo_en       (fifo_en),
    .de_i          (de_i),
    .hs_i          (hs_i),
    .vs_i          (vs_i),
    .pix_o         (pix_o),
    .de_o          (de_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt),
    .armed         (armed)
  );

  // Clock
  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // One pixel-clock cycle: drive inputs, present FIFO head, clock, pop if handshaken.
  task automatic cyc(input logic rst, input logic de, input logic hs, input logic vs);
    rd_rst   = rst;
    de_i     = de;
    hs_i     = hs;
    vs_i     = vs;
    fifo_vld = (exp_q.size() != 0);
    fifo_data = fifo_vld ? exp_q[0] : 32'hBAD0_BAD0;
    #1;
    en_seen = (fifo_en === 1'b1);
    if (en_seen) en_cnt++;
    @(posedge rd_clk);
    if (en_seen && fifo_vld) begin
      void'(exp_q.pop_front());
      pop_cnt++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0; en_seen = 1'b0; pop_cnt = 0; en_cnt = 0;
    rd_rst = 1'b1; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    fifo_vld = 1'b0; fifo_data = '0;

    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_pix", pix_o, 32'h0);
    chk("rst_de", de_o, 0);
    chk("rst_hs", hs_o, 0);
    chk("rst_vs", vs_o, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_cnt", underflow_cnt, 32'h0);
    chk("rst_armed", armed, 0);

    // vs edge with empty FIFO must not arm
    cyc(0, 0, 0, 1);
    chk("noarm_empty", armed, 0);
    cyc(0, 0, 0, 0);

    // Test 1: preloaded FIFO, de before any vs edge
    exp_q.push_back(32'h2222_1111);
    exp_q.push_back(32'h4444_3333);
    en_cnt = 0;
    cyc(0, 1, 0, 0);
    chk("t1_pix0", pix_o, 32'h0);
    cyc(0, 1, 0, 0);
    chk("t1_pix1", pix_o, 32'h0);
    chk("t1_armed", armed, 0);
    chk("t1_en_never", en_cnt, 0);

    // Test 2: arm and unpack two words
    cyc(0, 0, 0, 1);
    chk("t2_armed", armed, 1);
    chk("t2_vs_o", vs_o, 1);
    pop_cnt = 0;
    cyc(0, 1, 1, 1);
    chk("t2_pix0", pix_o, 32'h1111);
    chk("t2_en0", en_seen, 0);
    chk("t2_de_o", de_o, 1);
    chk("t2_hs_o", hs_o, 1);
    cyc(0, 1, 0, 1);
    chk("t2_pix1", pix_o, 32'h2222);
    chk("t2_en1", en_seen, 1);
    chk("t2_hs_o_low", hs_o, 0);
    cyc(0, 1, 0, 1);
    chk("t2_pix2", pix_o, 32'h3333);
    chk("t2_en2", en_seen, 0);
    cyc(0, 1, 0, 1);
    chk("t2_pix3", pix_o, 32'h4444);
    chk("t2_en3", en_seen, 1);
    chk("t2_pops", pop_cnt, 2);
    cyc(0, 0, 0, 1);
    chk("t2_de_o_low", de_o, 0);
    chk("t2_blank", pix_o, 32'h0);

    // Test 3: underflow with empty FIFO for 3 de cycles (lanes 0,1,0)
    cyc(0, 1, 0, 1);
    chk("t3_pix0", pix_o, 32'h0);
    chk("t3_uf0", underflow, 1);
    cyc(0, 1, 0, 1);
    chk("t3_pix1", pix_o, 32'h0);
    chk("t3_uf1", underflow, 1);
    chk("t3_en_while_empty", en_seen, 1);
    cyc(0, 1, 0, 1);
    chk("t3_uf2", underflow, 1);
    cyc(0, 0, 0, 1);
    chk("t3_uf_end", underflow, 0);
`ifdef HDMI_UNPACK_UFCNT_EN
    chk("t3_cnt", underflow_cnt, 32'd3);
`else
    chk("t3_cnt", underflow_cnt, 32'd0);
`endif

    // Test 4: lane is 1 here; vs edge together with de forces lane 0
    cyc(0, 0, 0, 0);
    exp_q.push_back(32'h6666_5555);
    cyc(0, 1, 0, 1);
    chk("t4_pix_lane0", pix_o, 32'h5555);
    chk("t4_no_pop", en_seen, 0);
    chk("t4_armed", armed, 1);
    cyc(0, 1, 0, 1);
    chk("t4_pix_lane1", pix_o, 32'h6666);
    chk("t4_pop", en_seen, 1);
    chk("t4_q_empty", exp_q.size(), 0);

    // Test 5: reset mid-line at lane 1
    exp_q.push_back(32'h8888_7777);
    exp_q.push_back(32'hAAAA_9999);
    cyc(0, 1, 0, 1);
    chk("t5_pix0", pix_o, 32'h7777);
    pop_cnt = 0;
    cyc(1, 1, 1, 1);
    chk("t5_pix", pix_o, 32'h0);
    chk("t5_de", de_o, 0);
    chk("t5_hs", hs_o, 0);
    chk("t5_vs", vs_o, 0);
    chk("t5_uf", underflow, 0);
    chk("t5_armed", armed, 0);
    chk("t5_no_pop", pop_cnt, 0);
    chk("t5_cnt", underflow_cnt, 32'h0);
    // re-arm on the next vs edge, starting again at lane 0
    cyc(0, 0, 0, 1);
    chk("t5_rearm", armed, 1);
    cyc(0, 1, 0, 1);
    chk("t5_pix_after", pix_o, 32'h7777);
    cyc(0, 1, 0, 1);
    chk("t5_pix_after1", pix_o, 32'h8888);

`ifdef HDMI_UNPACK_UFCNT_EN
    // Test 6: counter saturation (two data pixels then 65540 underflows)
    for (int i = 0; i < 65542; i++) cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t6_sat", underflow_cnt, 32'h0000_FFFF);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t6_sat_hold", underflow_cnt, 32'h0000_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
